// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types for the per-slave arbiter: transfer types and arbiter FSM encoding.
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef logic [1:0] arb_state_type;

  localparam arb_state_type ARB_IDLE  = 2'd0;
  localparam arb_state_type ARB_BURST = 2'd1;
  localparam arb_state_type ARB_LOCK  = 2'd2;

  // Transfer types that carry a data beat.
  function automatic logic htrans_has_data(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

  // Transfer types that continue the burst already owned by a master.
  function automatic logic htrans_continues(input htrans_type t);
    return (t == SEQ) || (t == BUSY);
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Bundle between the master-side decoders and one slave-port arbiter.
interface ahb_slave_arbiter_if #(
  parameter int MASTER_NUM = 4
);
  import ahb_slave_arbiter_pkg::*;

  localparam int MIDX_W = $clog2(MASTER_NUM);

  logic       [MASTER_NUM-1:0] hreq_m;
  htrans_type [MASTER_NUM-1:0] htrans_m;
  logic       [MASTER_NUM-1:0] hmastlock_m;
  logic                        hready;
  logic       [MASTER_NUM-1:0] hgrant;
  logic                        hsel;
  logic       [MIDX_W-1:0]     hmaster;
  logic       [MIDX_W-1:0]     hmaster_d;
  logic                        hdata_vld;

  modport master (
    output hreq_m, htrans_m, hmastlock_m, hready,
    input  hgrant, hsel, hmaster, hmaster_d, hdata_vld
  );

  modport slave (
    input  hreq_m, htrans_m, hmastlock_m, hready,
    output hgrant, hsel, hmaster, hmaster_d, hdata_vld
  );

endinterface

// File: rtl/ahb_slave_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module ahb_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_gnt   = N'(1) << w_cand;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: zero-latency one-hot grant with burst/lock ownership and data-phase tracking.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 4
) (
  input  logic             hclk,
  input  logic             hreset_n,
  ahb_slave_arbiter_if.slave bus
);

  localparam int MIDX_W = $clog2(MASTER_NUM);

  arb_state_type           r_state;
  logic [MIDX_W-1:0]       r_owner;
  logic [MIDX_W-1:0]       r_rr_ptr;
  logic [MASTER_NUM-1:0]   r_hgrant_q;
  logic [MIDX_W-1:0]       r_hmaster_d;
  logic                    r_hdata_vld;

  logic [MASTER_NUM-1:0]   w_rr_gnt;
  logic [MIDX_W-1:0]       w_rr_idx;
  logic [MIDX_W-1:0]       w_frz_idx;
  logic                    w_owner_keep;
  logic [MASTER_NUM-1:0]   w_hgrant;
  logic [MIDX_W-1:0]       w_hmaster;
  logic                    w_g_any;
  htrans_type              w_t_g;
  logic                    w_lk_g;
  arb_state_type           w_state_nxt;

  ahb_rr_picker #(
    .N     (MASTER_NUM),
    .IDX_W (MIDX_W)
  ) u_rr (
    .i_req (bus.hreq_m),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx)
  );

  // A burst owner keeps the slave only while continuing (SEQ/BUSY) or locked;
  // an owner NONSEQ starts a new burst and competes with rr_ptr pointing at itself.
  always_comb begin
    w_owner_keep = 1'b0;
    case (r_state)
      ARB_BURST: w_owner_keep = bus.hreq_m[r_owner] &
                                htrans_continues(bus.htrans_m[r_owner]);
      ARB_LOCK:  w_owner_keep = bus.hreq_m[r_owner] &
                                (bus.hmastlock_m[r_owner] |
                                 htrans_continues(bus.htrans_m[r_owner]));
      default:   w_owner_keep = 1'b0;
    endcase
  end

  always_comb begin
    w_frz_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (r_hgrant_q[i]) w_frz_idx = MIDX_W'(i);
    end
  end

  // Grant is gated by reset so outputs clear asynchronously even with requests pending.
  always_comb begin
    w_hgrant  = '0;
    w_hmaster = '0;
    if (hreset_n) begin
      if (!bus.hready) begin
        w_hgrant  = r_hgrant_q;
        w_hmaster = w_frz_idx;
      end else if (w_owner_keep) begin
        w_hgrant  = MASTER_NUM'(1) << r_owner;
        w_hmaster = r_owner;
      end else begin
        w_hgrant  = w_rr_gnt;
        w_hmaster = w_rr_idx;
      end
    end
  end

  assign w_g_any = |w_hgrant;
  assign w_t_g   = bus.htrans_m[w_hmaster];
  assign w_lk_g  = bus.hmastlock_m[w_hmaster];

  // Ownership always follows the current grantee, so a fresh grant after a lock
  // release is tracked from its NONSEQ beat onward.
  always_comb begin
    w_state_nxt = ARB_IDLE;
    if (w_g_any) begin
      if (w_lk_g)
        w_state_nxt = ARB_LOCK;
      else if ((w_t_g == NONSEQ) ||
               ((r_state != ARB_IDLE) && htrans_continues(w_t_g)))
        w_state_nxt = ARB_BURST;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= MIDX_W'(MASTER_NUM - 1);
      r_hgrant_q  <= '0;
      r_hmaster_d <= '0;
      r_hdata_vld <= 1'b0;
    end else begin
      r_hgrant_q <= w_hgrant;
      if (bus.hready) begin
        r_state     <= w_state_nxt;
        r_hmaster_d <= w_hmaster;
        r_hdata_vld <= w_g_any & htrans_has_data(w_t_g);
        if (w_g_any) r_owner <= w_hmaster;
        if (w_g_any && (w_t_g == NONSEQ)) r_rr_ptr <= w_hmaster;
      end
    end
  end

  assign bus.hgrant    = w_hgrant;
  assign bus.hsel      = w_g_any;
  assign bus.hmaster   = w_hmaster;
  assign bus.hmaster_d = r_hmaster_d;
  assign bus.hdata_vld = r_hdata_vld;

endmodule
